alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one 4-bit ALU instance between two requesters using valid/ready handshakes.
- Arbitrates round-robin by default, or fixed priority when the parameter selects it.
- Captures the winner's operands, executes one ALU operation and returns a registered result to the winning port only.
- Sits between the lab's control logic or requesters and the ALU datapath.

Parameters:
FIXED_PRIORITY, 0, 0 = round-robin between ports; 1 = port 0 always wins when both are valid

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  port 0 request valid
req0_ready  output  1  port 0 request accepted this cycle
req0_a  input  4  port 0 operand A
req0_b  input  4  port 0 operand B
req0_cmd  input  3  port 0 ALU command
rsp0_valid  output  1  result valid for port 0
rsp0_ready  input  1  port 0 consumes result
req1_valid  input  1  port 1 request valid
req1_ready  output  1  port 1 request accepted this cycle
req1_a  input  4  port 1 operand A
req1_b  input  4  port 1 operand B
req1_cmd  input  3  port 1 ALU command
rsp1_valid  output  1  result valid for port 1
rsp1_ready  input  1  port 1 consumes result
rsp_result  output  4  registered ALU result, meaningful while either rsp valid is high
rsp_zero  output  1  high when rsp_result == 0
busy  output  1  high in EXEC or RESP

Behaviour:
- Clock and reset: one clock domain, clk; reset is asynchronous and active-high.
- Reset values:
  - State = IDLE, prio = 0.
  - Captured a/b/cmd/owner = 0.
  - rsp_result = 0, rsp_zero = 0.
  - All valid and ready outputs = 0; req ready is forced low while reset is high.
- ALU function, combinational on the captured operands, 4-bit results:
  - 000 A&B; 001 A|B; 010 A+B mod 16; 011 0000.
  - 100 A&~B; 101 A|~B; 110 A-B mod 16.
  - 111 0001 if A<B unsigned, else 0000.
- State IDLE:
  - grant = port with valid high. If both are valid, the port indicated by prio wins (FIXED_PRIORITY=1: port 0 wins).
  - reqN_ready = 1 only for the granted port; it is combinational from valid and state.
  - On handshake (valid & ready): capture a, b, cmd and owner = N, then go to EXEC.
  - No valid request: stay in IDLE.
- State EXEC, exactly one cycle:
  - rsp_result <= alu_out.
  - rsp_zero <= (alu_out == 0).
  - Go to RESP.
- State RESP:
  - rspN_valid = (owner == N).
  - Result and zero flag are held stable until the owner asserts rsp_ready.
  - On handshake: go to IDLE; prio <= ~owner (round-robin only).
- Request-side rules outside IDLE:
  - Both req_ready stay low in EXEC and RESP.
  - Requests stay pending; no new request is accepted.
  - Latency from request handshake to rsp_valid: 2 cycles. Minimum throughput: 1 operation per 3 cycles.
- Invariants:
  - rsp_ready on the non-owner port is ignored.
  - Operand changes after the handshake are ignored.
  - Never more than one ready and never more than one rsp_valid high at a time.
  - A request that drops valid before grant is not served.
- Reset mid-operation: the in-flight transaction is discarded, no response is issued, and the block returns to IDLE with prio = 0.

Decomposition:
- Shared package alu_pkg holds:
  - The 3-bit command constants CMD_AND, CMD_OR, CMD_ADD, CMD_ANDN, CMD_ORN, CMD_SUB, CMD_SLT.
  - The state encoding IDLE/EXEC/RESP.
- One sub-module: alu_core, the combinational 4-bit ALU (a, b, cmd -> result). alu_arbiter instantiates it once.

Test Plan:
- Reset, then only req0 with a=3, b=5, cmd=010 -> req0_ready=1 in the same cycle; two cycles later rsp0_valid=1, rsp_result=1000, rsp_zero=0; rsp1_valid stays 0.
- Both ports valid in the same cycle with prio=0: port0 a=7,b=2,cmd=110; port1 a=2,b=9,cmd=111 -> port0 served first with result 0101; after rsp0 handshake, port1 is granted with result 0001.
- Both ports valid continuously for 4 transactions -> grants alternate 0,1,0,1; with FIXED_PRIORITY=1 all 4 grants go to port 0.
- Backpressure: hold rsp0_ready=0 for 5 cycles after a=12,b=10,cmd=000 -> rsp_result=1000 held stable; both req_ready=0 throughout; rsp1_ready=1 has no effect.
- Zero and wrap cases: a=15,b=1,cmd=010 -> 0000 with rsp_zero=1; a=0,b=1,cmd=110 -> 1111; cmd=011 -> 0000.
- Reset asserted in EXEC -> no rsp_valid; state IDLE and all outputs 0 immediately; the next request is served normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Contents:
//   DATA_W / CMD_W  - operand and command widths
//   CMD_*           - 3-bit ALU command encodings
//   state_t         - arbiter FSM state encoding (IDLE / EXEC / RESP)
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int CMD_W  = 3;

  localparam logic [CMD_W-1:0] CMD_AND  = 3'b000;
  localparam logic [CMD_W-1:0] CMD_OR   = 3'b001;
  localparam logic [CMD_W-1:0] CMD_ADD  = 3'b010;
  localparam logic [CMD_W-1:0] CMD_ZERO = 3'b011;
  localparam logic [CMD_W-1:0] CMD_ANDN = 3'b100;
  localparam logic [CMD_W-1:0] CMD_ORN  = 3'b101;
  localparam logic [CMD_W-1:0] CMD_SUB  = 3'b110;
  localparam logic [CMD_W-1:0] CMD_SLT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 4-bit ALU.
// Ports:
//   a, b   - unsigned operands
//   cmd    - operation select (see alu_pkg CMD_* constants)
//   result - 4-bit result; arithmetic wraps mod 16
module alu_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [CMD_W-1:0]  cmd,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (cmd)
      CMD_AND:  result = a & b;
      CMD_OR:   result = a | b;
      CMD_ADD:  result = a + b;
      CMD_ZERO: result = '0;
      CMD_ANDN: result = a & ~b;
      CMD_ORN:  result = a | ~b;
      CMD_SUB:  result = a - b;
      CMD_SLT:  result = {{(DATA_W-1){1'b0}}, (a < b)};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single shared ALU.
// A request is accepted in IDLE, its operands are captured, the ALU result is
// registered in EXEC, and the result is offered only to the winning port in
// RESP until that port consumes it.
// Ports:
//   clk, reset                      - clock, asynchronous active-high reset
//   reqN_valid/ready, reqN_a/b/cmd  - request handshake and operands, N = 0,1
//   rspN_valid/ready                - response handshake, N = 0,1
//   rsp_result, rsp_zero            - registered result and its zero flag
//   busy                            - high while an operation is in flight
// Parameter:
//   FIXED_PRIORITY - 0: round-robin on contention, 1: port 0 always wins
module alu_arbiter
  import alu_pkg::*;
#(
  parameter logic FIXED_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CMD_W-1:0]  req0_cmd,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CMD_W-1:0]  req1_cmd,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              busy
);

  state_t              state_q, state_d;
  logic                prio_q, prio_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;

  logic [DATA_W-1:0]   alu_out;
  logic                win1;
  logic                grant0;
  logic                grant1;

  alu_core u_alu_core (
    .a      (a_q),
    .b      (b_q),
    .cmd    (cmd_q),
    .result (alu_out)
  );

  // On contention port 1 wins only when round-robin points at it.
  assign win1   = FIXED_PRIORITY ? 1'b0 : prio_q;
  assign grant0 = req0_valid & (~req1_valid | ~win1);
  assign grant1 = req1_valid & (~req0_valid | win1);

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    a_d        = a_q;
    b_d        = b_q;
    cmd_d      = cmd_q;
    owner_d    = owner_q;
    result_d   = result_q;
    zero_d     = zero_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;

    case (state_q)
      IDLE: begin
        // Ready is masked by reset so nothing can look accepted while the
        // flops are being held in reset.
        req0_ready = grant0 & ~reset;
        req1_ready = grant1 & ~reset;
        if (req0_ready) begin
          a_d     = req0_a;
          b_d     = req0_b;
          cmd_d   = req0_cmd;
          owner_d = 1'b0;
          state_d = EXEC;
        end else if (req1_ready) begin
          a_d     = req1_a;
          b_d     = req1_b;
          cmd_d   = req1_cmd;
          owner_d = 1'b1;
          state_d = EXEC;
        end
      end

      EXEC: begin
        result_d = alu_out;
        zero_d   = (alu_out == '0);
        state_d  = RESP;
      end

      RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        // Only the owner's rsp_ready can complete the response.
        if ((rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready)) begin
          state_d = IDLE;
          if (!FIXED_PRIORITY) begin
            prio_d = ~owner_q;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cmd_q    <= '0;
      owner_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cmd_q    <= cmd_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic       clk;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_cmd, req1_cmd;
  logic       rsp0_ready, rsp1_ready;

  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, busy;
  logic [3:0] rsp_result;

  logic       f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_rsp_zero, f_busy;
  logic [3:0] f_rsp_result;

  int total;
  int bad;

  alu_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
  );

  alu_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fixed (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
    .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(f_rsp_result), .rsp_zero(f_rsp_zero), .busy(f_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse reset across one full clock period, starting just after a negedge.
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Inputs are already set just after a negedge in IDLE. Runs one transaction
  // of 3 cycles, consuming the response with both rsp_ready lines high, and
  // returns just after the negedge where the arbiter is back in IDLE.
  task automatic run_op(input string tag, input int port, input logic [3:0] res, input logic zf);
    #1;
    chk({tag, ":rdy0"}, {3'b0, req0_ready}, {3'b0, port == 0});
    chk({tag, ":rdy1"}, {3'b0, req1_ready}, {3'b0, port == 1});
    @(negedge clk);
    chk({tag, ":exec_busy"}, {3'b0, busy}, 4'd1);
    chk({tag, ":exec_rdy"}, {2'b0, req0_ready, req1_ready}, 4'd0);
    chk({tag, ":exec_rspv"}, {2'b0, rsp0_valid, rsp1_valid}, 4'd0);
    @(negedge clk);
    chk({tag, ":rspv0"}, {3'b0, rsp0_valid}, {3'b0, port == 0});
    chk({tag, ":rspv1"}, {3'b0, rsp1_valid}, {3'b0, port == 1});
    chk({tag, ":result"}, rsp_result, res);
    chk({tag, ":zero"}, {3'b0, rsp_zero}, {3'b0, zf});
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_cmd = '0;
    req1_a = '0; req1_b = '0; req1_cmd = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset state; ready is masked while reset is high even with valid set
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    chk("rst:rdy", {2'b0, req0_ready, req1_ready}, 4'd0);
    chk("rst:rspv", {2'b0, rsp0_valid, rsp1_valid}, 4'd0);
    chk("rst:result", rsp_result, 4'd0);
    chk("rst:zero_busy", {2'b0, rsp_zero, busy}, 4'd0);

    // Single request on port 0: 3+5 = 8
    @(negedge clk);
    reset = 1'b0;
    req0_a = 4'd3; req0_b = 4'd5; req0_cmd = 3'b010;
    run_op("add35", 0, 4'h8, 1'b0);
    req0_valid = 1'b0;
    #1;
    chk("add35:idle", {2'b0, busy, rsp0_valid}, 4'd0);

    // Contention with prio=0: port 0 first (7-2=5), then port 1 (2<9 -> 1)
    @(negedge clk);
    do_reset();
    req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd2; req0_cmd = 3'b110;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd9; req1_cmd = 3'b111;
    run_op("both_p0", 0, 4'h5, 1'b0);
    req0_valid = 1'b0;
    run_op("both_p1", 1, 4'h1, 1'b0);
    req1_valid = 1'b0;

    // Continuous contention: round-robin alternates, fixed priority stays on 0
    @(negedge clk);
    do_reset();
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_cmd = 3'b010;
    req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd3; req1_cmd = 3'b010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("fixed%0d:rdy0", i), {3'b0, f_req0_ready}, 4'd1);
      chk($sformatf("fixed%0d:rdy1", i), {3'b0, f_req1_ready}, 4'd0);
      run_op($sformatf("rr%0d", i), i % 2, (i % 2 == 0) ? 4'h2 : 4'h6, 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure: 12&10 = 8 held while rsp0_ready is low; rsp1_ready ignored
    @(negedge clk);
    do_reset();
    req0_valid = 1'b1; req0_a = 4'd12; req0_b = 4'd10; req0_cmd = 3'b000;
    req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd6; req1_cmd = 3'b110;
    #1;
    chk("bp:rdy0", {3'b0, req0_ready}, 4'd1);
    @(negedge clk);
    req0_a = 4'd0;
    req0_cmd = 3'b011;
    @(negedge clk);
    rsp1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d:rspv", i), {2'b0, rsp0_valid, rsp1_valid}, 4'b0010);
      chk($sformatf("bp%0d:result", i), rsp_result, 4'h8);
      chk($sformatf("bp%0d:zero", i), {3'b0, rsp_zero}, 4'd0);
      chk($sformatf("bp%0d:rdy", i), {2'b0, req0_ready, req1_ready}, 4'd0);
      @(negedge clk);
    end
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    req0_valid = 1'b0;
    // Pending port 1 is served next: 4-6 wraps to 14
    run_op("bp_p1", 1, 4'hE, 1'b0);
    req1_valid = 1'b0;

    // Zero and wrap cases on port 0
    req0_valid = 1'b1;
    req0_a = 4'd15; req0_b = 4'd1; req0_cmd = 3'b010;
    run_op("wrap_add", 0, 4'h0, 1'b1);
    req0_a = 4'd0; req0_b = 4'd1; req0_cmd = 3'b110;
    run_op("wrap_sub", 0, 4'hF, 1'b0);
    req0_a = 4'd5; req0_b = 4'd3; req0_cmd = 3'b011;
    run_op("zero_cmd", 0, 4'h0, 1'b1);
    req0_a = 4'd5; req0_b = 4'd3; req0_cmd = 3'b100;
    run_op("andn", 0, 4'h4, 1'b0);
    req0_a = 4'd5; req0_b = 4'd3; req0_cmd = 3'b101;
    run_op("orn", 0, 4'hD, 1'b0);
    req0_valid = 1'b0;

    // Reset while in EXEC discards the operation
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd2; req1_cmd = 3'b010;
    #1;
    chk("rexec:rdy1", {3'b0, req1_ready}, 4'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    chk("rexec:busy", {3'b0, busy}, 4'd1);
    reset = 1'b1;
    #1;
    chk("rexec:busy_off", {3'b0, busy}, 4'd0);
    chk("rexec:rspv", {2'b0, rsp0_valid, rsp1_valid}, 4'd0);
    chk("rexec:result", rsp_result, 4'd0);
    chk("rexec:zero", {3'b0, rsp_zero}, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rexec:no_rsp", {2'b0, rsp0_valid, rsp1_valid}, 4'd0);
    // prio is back to 0 after reset: port 0 wins contention (2-2=0)
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd2; req0_cmd = 3'b110;
    req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd3; req1_cmd = 3'b001;
    run_op("post_p0", 0, 4'h0, 1'b1);
    req0_valid = 1'b0;
    run_op("post_p1", 1, 4'hB, 1'b0);
    req1_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
